// File: rtl/pll_det_pkg.sv
// Shared types and constants for the PLL frequency-ratio lock detector.
package pll_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    COUNT
  } det_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/pll_lock_det_if.sv
// Signal bundle between the lock detector and its environment.
// PLL_LOCK_DET_STICKY_EN adds the lost_clr / lost_lock pair.
interface pll_lock_det_if #(
  parameter int unsigned CNT_W = 12
);
  logic             enable;
  logic             clkin;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             freq_high;
  logic             freq_low;
  logic             ref_lost;
  logic             locked;
`ifdef PLL_LOCK_DET_STICKY_EN
  logic             lost_clr;
  logic             lost_lock;
`endif

  modport master (
    output enable,
    output clkin,
    input  count,
    input  count_valid,
    input  freq_high,
    input  freq_low,
    input  ref_lost,
    input  locked
`ifdef PLL_LOCK_DET_STICKY_EN
    ,
    output lost_clr,
    input  lost_lock
`endif
  );

  modport slave (
    input  enable,
    input  clkin,
    output count,
    output count_valid,
    output freq_high,
    output freq_low,
    output ref_lost,
    output locked
`ifdef PLL_LOCK_DET_STICKY_EN
    ,
    input  lost_clr,
    output lost_lock
`endif
  );

endinterface

// File: rtl/ref_edge_sync.sv
// Brings the asynchronous reference clock into the clk domain and flags each
// rising edge with a one-cycle registered pulse (3 clk cycles after the rise).
module ref_edge_sync
  import pll_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clkin,
  output logic ref_edge
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      prev     <= 1'b0;
      ref_edge <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], clkin};
      prev     <= sync[SYNC_STAGES-1];
      ref_edge <= sync[SYNC_STAGES-1] & ~prev;
    end
  end

endmodule

// File: rtl/pll_lock_det.sv
// Frequency-ratio lock detector: counts clk cycles per REF_CYCLES reference
// periods, grades each window, and debounces a locked flag.
// Optional sticky loss-of-lock flag under PLL_LOCK_DET_STICKY_EN.
module pll_lock_det
  import pll_det_pkg::*;
#(
  parameter int unsigned REF_CYCLES  = 16,
  parameter int unsigned EXPECTED    = 160,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOCK_WINS   = 4,
  parameter int unsigned UNLOCK_WINS = 2,
  parameter int unsigned CNT_W       = 12
) (
  input logic           clk,
  input logic           rst,
  pll_lock_det_if.slave bus
);

  localparam int unsigned REF_W   = $clog2(REF_CYCLES + 1);
  localparam int unsigned RUN_MAX = (LOCK_WINS > UNLOCK_WINS) ? LOCK_WINS : UNLOCK_WINS;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
  localparam int unsigned DIFF_W  = CNT_W + 1;

  localparam logic [CNT_W-1:0]         CNT_MAX  = '1;
  localparam logic [REF_W-1:0]         REF_LAST = REF_W'(REF_CYCLES - 1);
  localparam logic signed [DIFF_W-1:0] EXP_S    = DIFF_W'(EXPECTED);
  localparam logic signed [DIFF_W-1:0] TOL_S    = DIFF_W'(TOL);

  det_state_t        state, state_nxt;
  logic [CNT_W-1:0]  win_cnt, win_nxt;
  logic [REF_W-1:0]  ref_cnt, ref_nxt;
  logic [RUN_W-1:0]  good_run, good_nxt;
  logic [RUN_W-1:0]  bad_run, bad_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              valid_q, valid_nxt;
  logic              high_q, high_nxt;
  logic              low_q, low_nxt;
  logic              lost_q, lost_nxt;
  logic              locked_q, locked_nxt;

  logic              ref_edge;
  logic signed [DIFF_W-1:0] diff_c;
  logic              high_c, low_c;
  logic              sat, win_done, win_good;

  ref_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clkin    (bus.clkin),
    .ref_edge (ref_edge)
  );

  // Deviation from nominal in one extra bit so large counts cannot wrap.
  assign diff_c = $signed({1'b0, win_cnt}) - EXP_S;
  assign high_c = diff_c > TOL_S;
  assign low_c  = diff_c < -TOL_S;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      win_cnt  <= '0;
      ref_cnt  <= '0;
      good_run <= '0;
      bad_run  <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      high_q   <= 1'b0;
      low_q    <= 1'b0;
      lost_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      win_cnt  <= win_nxt;
      ref_cnt  <= ref_nxt;
      good_run <= good_nxt;
      bad_run  <= bad_nxt;
      count_q  <= count_nxt;
      valid_q  <= valid_nxt;
      high_q   <= high_nxt;
      low_q    <= low_nxt;
      lost_q   <= lost_nxt;
      locked_q <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    win_nxt    = win_cnt;
    ref_nxt    = ref_cnt;
    good_nxt   = good_run;
    bad_nxt    = bad_run;
    count_nxt  = count_q;
    valid_nxt  = 1'b0;
    high_nxt   = high_q;
    low_nxt    = low_q;
    lost_nxt   = lost_q;
    locked_nxt = locked_q;
    sat        = 1'b0;
    win_done   = 1'b0;
    win_good   = 1'b0;

    if (!bus.enable) begin
      // Partial window discarded; count and direction flags keep last result.
      state_nxt  = IDLE;
      win_nxt    = '0;
      ref_nxt    = '0;
      good_nxt   = '0;
      bad_nxt    = '0;
      lost_nxt   = 1'b0;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ALIGN;
          win_nxt   = '0;
          ref_nxt   = '0;
        end
        ALIGN: begin
          if (ref_edge) begin
            state_nxt = COUNT;
            win_nxt   = CNT_W'(1);
            ref_nxt   = '0;
          end else if (win_cnt == CNT_MAX) begin
            sat = 1'b1;
          end else begin
            win_nxt = win_cnt + CNT_W'(1);
          end
        end
        COUNT: begin
          if (ref_edge && ref_cnt == REF_LAST) begin
            win_done  = 1'b1;
            win_good  = ~high_c & ~low_c;
            count_nxt = win_cnt;
            high_nxt  = high_c;
            low_nxt   = low_c;
            lost_nxt  = 1'b0;
            win_nxt   = CNT_W'(1);
            ref_nxt   = '0;
          end else if (ref_edge) begin
            // An edge beats saturation; the counter just stops at its ceiling.
            ref_nxt = ref_cnt + REF_W'(1);
            if (win_cnt != CNT_MAX) win_nxt = win_cnt + CNT_W'(1);
          end else if (win_cnt == CNT_MAX) begin
            sat = 1'b1;
          end else begin
            win_nxt = win_cnt + CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (sat) begin
        state_nxt = ALIGN;
        win_nxt   = '0;
        ref_nxt   = '0;
        count_nxt = CNT_MAX;
        high_nxt  = 1'b0;
        low_nxt   = 1'b0;
        lost_nxt  = 1'b1;
        win_done  = 1'b1;
        win_good  = 1'b0;
      end

      // Lock debounce, applied on every reported window.
      if (win_done) begin
        valid_nxt = 1'b1;
        if (win_good) begin
          bad_nxt = '0;
          if (good_run < RUN_W'(LOCK_WINS)) good_nxt = good_run + RUN_W'(1);
          if (good_nxt >= RUN_W'(LOCK_WINS)) locked_nxt = 1'b1;
        end else begin
          good_nxt = '0;
          if (bad_run < RUN_W'(UNLOCK_WINS)) bad_nxt = bad_run + RUN_W'(1);
          if (bad_nxt >= RUN_W'(UNLOCK_WINS)) locked_nxt = 1'b0;
        end
      end
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = valid_q;
  assign bus.freq_high   = high_q;
  assign bus.freq_low    = low_q;
  assign bus.ref_lost    = lost_q;
  assign bus.locked      = locked_q;

`ifdef PLL_LOCK_DET_STICKY_EN
  logic lost_lock_q;

  // Sticky record of any lock drop or reference loss while locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_lock_q <= 1'b0;
    end else if (bus.lost_clr) begin
      lost_lock_q <= 1'b0;
    end else if ((locked_q & ~locked_nxt) | (locked_q & ~lost_q & lost_nxt)) begin
      lost_lock_q <= 1'b1;
    end
  end

  assign bus.lost_lock = lost_lock_q;
`endif

endmodule

// File: tb/tb_pll_lock_det.sv
// Scoreboard bench for pll_lock_det: each reference window pushes its expected
// report, which is popped and compared when count_valid pulses.
module tb_pll_lock_det;

  localparam int unsigned CNT_W = 12;
  localparam int EXPECTED    = 160;
  localparam int TOL         = 2;
  localparam int LOCK_WINS   = 4;
  localparam int UNLOCK_WINS = 2;
  localparam int SAT_COUNT   = 4095;
  localparam int CLK_HALF    = 8;

  typedef struct {
    int   count;
    logic high;
    logic low;
    logic lost;
    logic locked;
  } exp_t;

  logic clk;
  logic rst;

  pll_lock_det_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_det #(
    .REF_CYCLES  (16),
    .EXPECTED    (EXPECTED),
    .TOL         (TOL),
    .LOCK_WINS   (LOCK_WINS),
    .UNLOCK_WINS (UNLOCK_WINS),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_good, m_bad, m_count;
  logic m_locked, m_high, m_low;

  // clk period is 16 time units, so a reference period of P units gives P clk
  // cycles per 16-period window.
  initial begin
    clk = 1'b0;
    forever #CLK_HALF clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_good   = 0;
    m_bad    = 0;
    m_locked = 1'b0;
  endtask

  task automatic model_window(input logic good);
    if (good) begin
      m_bad = 0;
      if (m_good < LOCK_WINS) m_good++;
      if (m_good >= LOCK_WINS) m_locked = 1'b1;
    end else begin
      m_good = 0;
      if (m_bad < UNLOCK_WINS) m_bad++;
      if (m_bad >= UNLOCK_WINS) m_locked = 1'b0;
    end
  endtask

  task automatic push_win(input int n);
    exp_t e;
    m_high = (n > EXPECTED + TOL);
    m_low  = (n < EXPECTED - TOL);
    model_window(!m_high && !m_low);
    m_count  = n;
    e.count  = n;
    e.high   = m_high;
    e.low    = m_low;
    e.lost   = 1'b0;
    e.locked = m_locked;
    sb.push_back(e);
  endtask

  task automatic push_sat();
    exp_t e;
    model_window(1'b0);
    m_count  = SAT_COUNT;
    m_high   = 1'b0;
    m_low    = 1'b0;
    e.count  = SAT_COUNT;
    e.high   = 1'b0;
    e.low    = 1'b0;
    e.lost   = 1'b1;
    e.locked = m_locked;
    sb.push_back(e);
  endtask

  // 16 reference periods of p units; edges stay on odd times, clear of clk edges.
  task automatic ref_block(input int p);
    int hi;
    hi = 2 * (p / 4);
    push_win(p);
    for (int i = 0; i < 16; i++) begin
      bus.clkin = 1'b1;
      #(hi);
      bus.clkin = 1'b0;
      #(p - hi);
    end
  endtask

  task automatic closing_rise();
    bus.clkin = 1'b1;
    #80;
    bus.clkin = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"},  int'(bus.count), 0);
    check({tag, "_valid"},  int'(bus.count_valid), 0);
    check({tag, "_high"},   int'(bus.freq_high), 0);
    check({tag, "_low"},    int'(bus.freq_low), 0);
    check({tag, "_lost"},   int'(bus.ref_lost), 0);
    check({tag, "_locked"}, int'(bus.locked), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.count_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("win_count",  int'(bus.count), e.count);
        check("win_high",   int'(bus.freq_high), int'(e.high));
        check("win_low",    int'(bus.freq_low), int'(e.low));
        check("win_lost",   int'(bus.ref_lost), int'(e.lost));
        check("win_locked", int'(bus.locked), int'(e.locked));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.clkin  = 1'b0;
`ifdef PLL_LOCK_DET_STICKY_EN
    bus.lost_clr = 1'b0;
`endif
    model_reset();
    m_count = 0;
    m_high  = 1'b0;
    m_low   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Lock at the nominal ratio, then exercise tolerance and unlock debounce.
    @(negedge clk);
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    repeat (5) ref_block(160);
    ref_block(150);
    ref_block(160);
    ref_block(150);
    ref_block(150);
    ref_block(162);
    ref_block(158);
    ref_block(164);
    repeat (4) ref_block(168);
    repeat (4) ref_block(160);
    closing_rise();
    wait_drain(40);
    check("locked_before_loss", int'(bus.locked), 1);

    // Reference stops: two saturated windows, then recovery.
    push_sat();
    push_sat();
    wait_drain(9000);
    @(negedge clk);
    #3;
    repeat (4) ref_block(160);
    closing_rise();
    wait_drain(40);

    // Drop enable mid-window.
    repeat (20) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("dis_locked", int'(bus.locked), 0);
    check("dis_count",  int'(bus.count), m_count);
    check("dis_high",   int'(bus.freq_high), int'(m_high));
    check("dis_low",    int'(bus.freq_low), int'(m_low));
    check("dis_lost",   int'(bus.ref_lost), 0);
    model_reset();
`ifdef PLL_LOCK_DET_STICKY_EN
    check("sticky_set", int'(bus.lost_lock), 1);
    repeat (3) @(negedge clk);
    check("sticky_hold", int'(bus.lost_lock), 1);
    bus.lost_clr = 1'b1;
    @(negedge clk);
    bus.lost_clr = 1'b0;
    check("sticky_clr", int'(bus.lost_lock), 0);
`endif

    // Re-enable restarts from alignment.
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    ref_block(160);
    closing_rise();
    wait_drain(40);

    // Asynchronous reset in the middle of a window.
    repeat (30) @(negedge clk);
    #5;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    bus.enable = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    bus.enable = 1'b1;
    repeat (300) @(negedge clk);
    check("rst_no_valid_pending", sb.size(), 0);
    check("rst_locked", int'(bus.locked), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
